spi_sample_averager: RTL and testbench
======================================

# spi_sample_averager

Downstream consumer of the SPI master's received byte. Detects the end of each SPI transaction from the chip-select line, captures the 8-bit byte the master has just loaded, and averages 2^AVG_LOG2 consecutive bytes. Each average is pushed into a small first-word-fall-through FIFO with a valid/ready output toward the sample consumer (display, UART, or threshold logic). Runs entirely in the 100 MHz system clock domain. The SPI master's CS and data are treated as slow, quasi-static inputs.

## Interface
- AVG_LOG2, 2: log2 of the number of bytes averaged. Legal range 0..4; 0 passes each byte through unchanged.
- FIFO_DEPTH, 4: number of averaged samples buffered. Power of two, ≥2.
- clk  input  1  system clock, 100 MHz (same clock that feeds the SPI clock divider)
- rst  input  1  reset: synchronous, active-high; single clock domain (clk only)
- cs_in  input  1  SPI master CS; a rising edge marks transaction complete
- data_in  input  8  SPI master received byte; stable from the CS rising edge until the next transaction ends
- sample_valid  output  1  FIFO non-empty
- sample_data  output  8  FIFO head; 8'h00 whenever sample_valid=0
- sample_ready  input  1  consumer accepts the head when sample_valid & sample_ready
- overflow  output  1  sticky: an average was dropped because the FIFO was full

## Operation
- CS synchronizer:
  - Two flops, cs_s1 and cs_s2, both reset to 1 (the idle CS level).
  - cs_prev is a registered copy of cs_s2, also reset to 1.
  - cs_rise = cs_s2 & ~cs_prev.
- The byte data_in is sampled only in S_ACCUM. It is never synchronized: its stability window is at least 16 SCLK periods.
- State machine, with state reset to S_IDLE:
  - S_IDLE → S_ACCUM on cs_rise. Otherwise stay in S_IDLE.
  - S_ACCUM performs acc += data_in and cnt += 1.
    - If cnt was 2^AVG_LOG2−1: go to S_EMIT.
    - Otherwise: go to S_IDLE.
  - S_EMIT computes avg = acc[AVG_LOG2+7:AVG_LOG2] (truncating, no rounding).
    - If the FIFO accepts, push avg. If not, drop it and set overflow.
    - Clear acc and cnt, then go to S_IDLE.
- Widths:
  - acc is AVG_LOG2+8 bits, unsigned; it cannot overflow.
  - cnt is max(AVG_LOG2,1) bits and wraps to 0.
- FIFO push acceptance: the push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Pop (sample_valid & sample_ready):
  - Advances the read pointer.
  - A pop on an empty FIFO is ignored.
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged and both are performed.
- overflow is cleared only by rst.
- A cs_rise that arrives while the FSM is in S_ACCUM or S_EMIT is impossible, since transactions are far slower than 3 cycles. It is not queued.
- Reset mid-operation discards the partial average, all FIFO contents, and overflow.
  - If cs_in is low at reset release, no edge is produced (the synchronizer resets to 1).
  - The first counted edge is the next low→high transition.

## Timing
- Reset values:
  - sample_valid=0, sample_data=8'h00, overflow=0.
  - acc=0, cnt=0, state S_IDLE, FIFO empty.
- Let edge 0 be the first clk edge that samples cs_in=1 after it was 0:
  - cs_s2 rises at edge 1; cs_rise is high in the cycle after edge 1.
  - S_ACCUM is entered at edge 2; the byte is accumulated at edge 3.
  - S_EMIT, when applicable, is entered at edge 3; the FIFO is written at edge 4.
  - sample_valid is high after edge 4, with sample_data = avg in the same cycle (FWFT).
- Latency from the final byte's CS rise to output: 5 clk edges. No added latency when the FIFO is already non-empty.
- Throughput: at most one push per 3 cycles, far above the SPI rate of one transaction per 24 SCLK.
- overflow rises the cycle after the dropped S_EMIT.

## Structure
- Shared package spi_pkg:
  - FSM state enum: S_IDLE, S_ACCUM, S_EMIT.
  - CS_IDLE=1'b1.
  - Default AVG_LOG2 and FIFO_DEPTH constants.
- One sub-module, sample_fifo:
  - Parameterised FWFT FIFO with push/full and pop/empty ports.
  - Pointers one bit wider than log2(FIFO_DEPTH) for full/empty discrimination.
  - Zeroed output when empty.
- Top level holds the synchronizer, edge detect, FSM and accumulator.

## Test plan
- Reset with cs_in=0, then release rst → no push. Then four CS pulses with data_in 8'h10, 8'h20, 8'h30, 8'h40 → one sample 8'h28, appearing 5 edges after the fourth rise.
- Bytes 8'hFF ×4 → 8'hFF. Bytes 8'h01, 8'h00, 8'h00, 8'h00 → 8'h00 (truncation).
- sample_ready=0, then 5 averages with FIFO_DEPTH=4 → 4 samples held, overflow=1. Drain → the 4 oldest values in order, then sample_valid=0 and sample_data=8'h00.
- FIFO full and sample_ready=1 in the same cycle as S_EMIT → push accepted, overflow stays 0, occupancy stays 4.
- Assert rst after 2 of 4 bytes, release, send 4 bytes of 8'h08 → output 8'h08 (partial sum discarded), overflow=0.
- AVG_LOG2=0 → every CS rise produces data_in unchanged at the output.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, CS idle level and default sizing for the SPI sample averager.
package spi_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;
  localparam logic CS_IDLE = 1'b1;
  localparam int AVG_LOG2_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with zeroed head when empty.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic pop_ok, push_ok;
  // a push into a full FIFO still lands when the head leaves in the same cycle
  always_comb begin
    empty = wptr == rptr;
    full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop_ok = pop && !empty;
    push_ok = push && (!full || pop_ok);
    dout = empty ? '0 : mem[rptr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_sample_averager.sv
// spi_sample_averager: averages 2^AVG_LOG2 SPI bytes captured on CS rising edges into a FWFT FIFO.
module spi_sample_averager
  import spi_pkg::*;
#(
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_in,
  input  logic [7:0] data_in,
  output logic       sample_valid,
  output logic [7:0] sample_data,
  input  logic       sample_ready,
  output logic       overflow
);
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int SW = AVG_LOG2 + 8;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  logic cs_s1, cs_s2, cs_prev, cs_rise;
  state_t state;
  logic [SW-1:0] acc;
  logic [CW-1:0] cnt;
  logic push, full, empty;
  logic [7:0] avg;
  always_comb begin
    cs_rise = cs_s2 & ~cs_prev;
    avg = acc[AVG_LOG2 +: 8];
    push = state == S_EMIT;
    sample_valid = !empty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1 <= CS_IDLE;
      cs_s2 <= CS_IDLE;
      cs_prev <= CS_IDLE;
      state <= S_IDLE;
      acc <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      cs_s1 <= cs_in;
      cs_s2 <= cs_s1;
      cs_prev <= cs_s2;
      case (state)
        S_IDLE: if (cs_rise) state <= S_ACCUM;
        S_ACCUM: begin
          acc <= acc + SW'(data_in);
          cnt <= cnt + 1'b1;
          state <= cnt == CNT_LAST ? S_EMIT : S_IDLE;
        end
        S_EMIT: begin
          // full FIFO is never empty, so sample_ready alone means the head leaves
          if (full && !sample_ready) overflow <= 1'b1;
          acc <= '0;
          cnt <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(avg),
    .full(full),
    .pop(sample_ready),
    .dout(sample_data),
    .empty(empty)
  );
endmodule

// File: tb/tb_spi_sample_averager.sv
// tb_spi_sample_averager: scoreboard bench for the averaging and pass-through configurations.
module tb_spi_sample_averager;
  logic clk = 0, rst = 1, cs_in = 0;
  logic [7:0] data_in = 0;
  logic valid, ready = 0, overflow;
  logic [7:0] data;
  logic valid0, ready0 = 0, ovf0;
  logic [7:0] data0;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];
  logic [7:0] e;

  always #5 clk = ~clk;

  spi_sample_averager #(.AVG_LOG2(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .cs_in(cs_in), .data_in(data_in),
    .sample_valid(valid), .sample_data(data), .sample_ready(ready), .overflow(overflow));

  spi_sample_averager #(.AVG_LOG2(0), .FIFO_DEPTH(4)) u_pass (
    .clk(clk), .rst(rst), .cs_in(cs_in), .data_in(data_in),
    .sample_valid(valid0), .sample_data(data0), .sample_ready(ready0), .overflow(ovf0));

  task automatic send_byte(input logic [7:0] b);
    cs_in = 0;
    data_in = b;
    repeat (3) @(negedge clk);
    cs_in = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cs_in = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || data !== 8'h00 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state valid=%b data=%h overflow=%b expected 0/00/0", valid, data, overflow);
    end
    rst = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_low_cs_no_push valid=%b valid0=%b expected 0/0", valid, valid0);
    end
  endtask

  task automatic test_basic();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    cs_in = 0;
    data_in = 8'h40;
    repeat (3) @(negedge clk);
    cs_in = 1;
    exp_q.push_back(8'h28);
    repeat (4) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early valid=%b after 4 edges expected 0", valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || data !== e) begin
      failures++;
      $display("FAIL latency_5_edges valid=%b data=%h expected 1/%h", valid, data, e);
    end
    ready = 1;
    @(negedge clk);
    ready = 0;
    checks++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      failures++;
      $display("FAIL basic_drained valid=%b data=%h expected 0/00", valid, data);
    end
  endtask

  task automatic test_values();
    logic [7:0] pat [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [7:0] avg [2] = '{8'hFF, 8'h00};
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) send_byte(pat[g*4+i]);
      exp_q.push_back(avg[g]);
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || data !== e) begin
        failures++;
        $display("FAIL values[%0d] valid=%b data=%h expected 1/%h", g, valid, data, e);
      end
      ready = 1;
      @(negedge clk);
      ready = 0;
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) send_byte(v[g]);
      exp_q.push_back(v[g]);
    end
    for (int i = 0; i < 3; i++) send_byte(8'hA5);
    cs_in = 0;
    data_in = 8'hA5;
    repeat (3) @(negedge clk);
    cs_in = 1;
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || data !== e) begin
      failures++;
      $display("FAIL full_pop_head valid=%b data=%h expected 1/%h", valid, data, e);
    end
    exp_q.push_back(8'hA5);
    ready = 1;
    @(negedge clk);
    ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_overflow overflow=%b expected 0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || data !== e) begin
        failures++;
        $display("FAIL full_pop_drain[%0d] valid=%b data=%h expected 1/%h", i, valid, data, e);
      end
      ready = 1;
      @(negedge clk);
      ready = 0;
    end
    checks++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      failures++;
      $display("FAIL full_pop_empty valid=%b data=%h expected 0/00", valid, data);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v [5] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    for (int g = 0; g < 5; g++) begin
      if (g == 4) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL overflow_early overflow=%b expected 0", overflow);
        end
      end
      for (int i = 0; i < 4; i++) send_byte(v[g]);
      if (g < 4) exp_q.push_back(v[g]);
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set overflow=%b expected 1", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || data !== e) begin
        failures++;
        $display("FAIL overflow_drain[%0d] valid=%b data=%h expected 1/%h", i, valid, data, e);
      end
      ready = 1;
      @(negedge clk);
      ready = 0;
    end
    checks++;
    if (valid !== 1'b0 || data !== 8'h00 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_after_drain valid=%b data=%h overflow=%b expected 0/00/1", valid, data, overflow);
    end
  endtask

  task automatic test_mid_reset();
    send_byte(8'h80);
    send_byte(8'h80);
    do_reset();
    checks++;
    if (overflow !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_clear overflow=%b valid=%b expected 0/0", overflow, valid);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h08);
    exp_q.push_back(8'h08);
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || data !== e || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_avg valid=%b data=%h overflow=%b expected 1/%h/0", valid, data, overflow, e);
    end
    ready = 1;
    @(negedge clk);
    ready = 0;
  endtask

  task automatic test_pass_through();
    logic [7:0] v [4] = '{8'h00, 8'h7E, 8'hFF, 8'h3C};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(v[i]);
      exp0_q.push_back(v[i]);
      e = exp0_q.pop_front();
      checks++;
      if (valid0 !== 1'b1 || data0 !== e) begin
        failures++;
        $display("FAIL pass_through[%0d] valid=%b data=%h expected 1/%h", i, valid0, data0, e);
      end
      ready0 = 1;
      @(negedge clk);
      ready0 = 0;
    end
    checks++;
    if (valid0 !== 1'b0 || ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL pass_through_end valid=%b overflow=%b expected 0/0", valid0, ovf0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_full_pop();
    test_overflow();
    test_mid_reset();
    test_pass_through();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
